pwm_capture: RTL and testbench

//  Receive-side counterpart of the fade/pwm LED path. Samples an external PWM line,

---
 rtl/pwm_pkg.sv | 12 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_pwm_capture.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants and capture state type
package pwm_pkg;

    localparam int PWM_INTERVAL_DEFAULT = 1200;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronized, resets to 0)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an external PWM line
// Ports: clk, rst_n (async, active-low), pwm_in (async PWM line),
//        duty_value/period_value/is_static (last report), valid (1-cycle report strobe),
//        locked (consecutive periods close to PWM_INTERVAL)
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter int TIMEOUT      = 2 * PWM_INTERVAL,
    parameter int TOL          = 4,
    parameter int LOCK_COUNT   = 4,
    parameter bit INVERT       = 1'b0,
    parameter int DW           = $clog2(PWM_INTERVAL + 1),
    parameter int CW           = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [DW-1:0] duty_value,
    output logic [CW-1:0] period_value,
    output logic          valid,
    output logic          is_static,
    output logic          locked
);

    localparam int LW = $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TOL_LO_C   = CW'((PWM_INTERVAL > TOL) ? (PWM_INTERVAL - TOL) : 0);
    localparam logic [CW-1:0] TOL_HI_C   = CW'(PWM_INTERVAL + TOL);
    localparam logic [CW-1:0] DUTY_MAX_C = CW'(PWM_INTERVAL);
    localparam logic [DW-1:0] DUTY_MAX_D = DW'(PWM_INTERVAL);
    localparam logic [LW-1:0] LOCK_C     = LW'(LOCK_COUNT);

    logic          pwm_sync;
    logic          s;
    logic          s_d;
    logic          rise;
    logic          fall;

    cap_state_t    state;
    cap_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] hi_len;
    logic [1:0]    fill_cnt;
    logic          seen_low;
    logic [LW-1:0] lock_cnt;

    logic          fill_done;
    logic          timeout;
    logic          acq_rise;
    logic          edge_pub;
    logic          static_pub;
    logic          in_tol;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (pwm_sync)
    );

    assign s    = pwm_sync ^ INVERT;
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_comb begin
        state_n    = state;
        acq_rise   = 1'b0;
        edge_pub   = 1'b0;
        fill_done  = (fill_cnt == 2'd2);
        timeout    = (cnt == TIMEOUT_C);
        cnt_inc    = timeout ? cnt : cnt + CW'(1);
        in_tol     = (cnt >= TOL_LO_C) && (cnt <= TOL_HI_C);
        case (state)
            ACQ: begin
                // A rise only counts once the line has been seen low, so a line
                // that is already high out of reset is not mistaken for an edge.
                if (fill_done && seen_low && rise) begin
                    state_n  = HIGH;
                    acq_rise = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n  = HIGH;
                    edge_pub = 1'b1;
                end
            end
            default: state_n = ACQ;
        endcase
        // Any edge that moves the FSM takes priority over a coincident timeout.
        static_pub = timeout && (state_n == state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACQ;
            s_d          <= 1'b0;
            cnt          <= '0;
            hi_len       <= '0;
            fill_cnt     <= 2'd0;
            seen_low     <= 1'b0;
            lock_cnt     <= '0;
            duty_value   <= '0;
            period_value <= '0;
            valid        <= 1'b0;
            is_static    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state <= state_n;
            s_d   <= s;
            valid <= 1'b0;

            if (!fill_done) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (state == ACQ && fill_done && !s) begin
                seen_low <= 1'b1;
            end

            if (acq_rise || edge_pub || static_pub) begin
                cnt <= CW'(1);
            end else begin
                cnt <= cnt_inc;
            end

            if (state == HIGH && fall) begin
                hi_len <= cnt;
            end

            if (edge_pub) begin
                valid        <= 1'b1;
                is_static    <= 1'b0;
                period_value <= cnt;
                duty_value   <= (hi_len > DUTY_MAX_C) ? DUTY_MAX_D : hi_len[DW-1:0];
                if (in_tol) begin
                    if (lock_cnt != LOCK_C) begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                    if (lock_cnt >= LOCK_C - LW'(1)) begin
                        locked <= 1'b1;
                    end
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end else if (static_pub) begin
                valid        <= 1'b1;
                is_static    <= 1'b1;
                period_value <= '0;
                duty_value   <= s ? DUTY_MAX_D : '0;
                lock_cnt     <= '0;
                locked       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int DW = 11;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic          pwm_inv = 1'b1;

    logic [DW-1:0] duty, duty_i;
    logic [CW-1:0] period, period_i;
    logic          valid, valid_i, stat, stat_i, locked, locked_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    typedef struct {
        int duty;
        int period;
        bit stat;
        bit locked;
        int cyc;
    } rep_t;

    rep_t q[$];
    rep_t qi[$];

    always #5 clk = ~clk;

    pwm_capture #(
        .PWM_INTERVAL (1200),
        .TIMEOUT      (2400),
        .TOL          (4),
        .LOCK_COUNT   (4),
        .INVERT       (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .duty_value   (duty),
        .period_value (period),
        .valid        (valid),
        .is_static    (stat),
        .locked       (locked)
    );

    pwm_capture #(
        .PWM_INTERVAL (1200),
        .TIMEOUT      (2400),
        .TOL          (4),
        .LOCK_COUNT   (4),
        .INVERT       (1'b1)
    ) dut_inv (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_inv),
        .duty_value   (duty_i),
        .period_value (period_i),
        .valid        (valid_i),
        .is_static    (stat_i),
        .locked       (locked_i)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && valid) begin
            rep_t r;
            r.duty = int'(duty); r.period = int'(period);
            r.stat = stat; r.locked = locked; r.cyc = cyc;
            q.push_back(r);
        end
        if (rst_n && valid_i) begin
            rep_t r2;
            r2.duty = int'(duty_i); r2.period = int'(period_i);
            r2.stat = stat_i; r2.locked = locked_i; r2.cyc = cyc;
            qi.push_back(r2);
        end
    end

    task automatic apply_reset(input logic lvl, input logic lvl_i);
        @(negedge clk);
        rst_n = 1'b0; pwm_in = lvl; pwm_inv = lvl_i;
        repeat (3) @(negedge clk);
        q.delete(); qi.delete();
        rst_n = 1'b1;
    endtask

    task automatic wave(input int hi, input int lo);
        pwm_in = 1'b1; repeat (hi) @(negedge clk);
        pwm_in = 1'b0; repeat (lo) @(negedge clk);
    endtask

    task automatic wave_inv(input int active, input int idle);
        pwm_inv = 1'b0; repeat (active) @(negedge clk);
        pwm_inv = 1'b1; repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({duty, period, valid, stat, locked} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {duty, period, valid, stat, locked});
        end
        n_tests++;
        if ({duty_i, period_i, valid_i, stat_i, locked_i} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_inv: got %h expected 0", {duty_i, period_i, valid_i, stat_i, locked_i});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if (q.size() != 0 || qi.size() != 0) begin
            n_fail++; $display("FAIL reset_no_valid: got %0d/%0d reports expected 0", q.size(), qi.size());
        end
    endtask

    task automatic test_duty25();
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (7) wave(300, 900);
        n_tests++;
        if (q.size() != 6) begin
            n_fail++; $display("FAIL duty25_count: got %0d expected 6", q.size());
        end
        for (int i = 0; i < q.size() && i < 6; i++) begin
            n_tests++;
            if (q[i].duty != 300 || q[i].period != 1200 || q[i].stat != 1'b0 || q[i].locked != (i >= 3)) begin
                n_fail++;
                $display("FAIL duty25[%0d]: got duty=%0d period=%0d static=%0d locked=%0d expected 300 1200 0 %0d",
                         i, q[i].duty, q[i].period, q[i].stat, q[i].locked, (i >= 3));
            end
            if (i > 0) begin
                n_tests++;
                if (q[i].cyc - q[i-1].cyc != 1200) begin
                    n_fail++; $display("FAIL duty25_spacing[%0d]: got %0d expected 1200", i, q[i].cyc - q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_relock();
        int exp_p[10] = '{1200, 1200, 1200, 1200, 1200, 1210, 1200, 1200, 1200, 1200};
        bit exp_l[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (5) wave(300, 900);
        wave(300, 910);
        repeat (5) wave(300, 900);
        n_tests++;
        if (q.size() != 10) begin
            n_fail++; $display("FAIL relock_count: got %0d expected 10", q.size());
        end
        for (int i = 0; i < q.size() && i < 10; i++) begin
            n_tests++;
            if (q[i].duty != 300 || q[i].period != exp_p[i] || q[i].locked != exp_l[i]) begin
                n_fail++;
                $display("FAIL relock[%0d]: got duty=%0d period=%0d locked=%0d expected 300 %0d %0d",
                         i, q[i].duty, q[i].period, q[i].locked, exp_p[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_tol_boundary();
        int exp_p[6] = '{1204, 1204, 1204, 1204, 1196, 1205};
        bit exp_l[6] = '{0, 0, 0, 1, 1, 0};
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (4) wave(300, 904);
        wave(300, 896);
        wave(300, 905);
        wave(300, 900);
        n_tests++;
        if (q.size() != 6) begin
            n_fail++; $display("FAIL tol_count: got %0d expected 6", q.size());
        end
        for (int i = 0; i < q.size() && i < 6; i++) begin
            n_tests++;
            if (q[i].period != exp_p[i] || q[i].locked != exp_l[i]) begin
                n_fail++;
                $display("FAIL tol[%0d]: got period=%0d locked=%0d expected %0d %0d",
                         i, q[i].period, q[i].locked, exp_p[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_short_pulse();
        int exp_d[4] = '{1, 1, 1199, 1199};
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (2) wave(1, 1199);
        repeat (2) wave(1199, 1);
        wave(300, 900);
        n_tests++;
        if (q.size() != 4) begin
            n_fail++; $display("FAIL short_count: got %0d expected 4", q.size());
        end
        for (int i = 0; i < q.size() && i < 4; i++) begin
            n_tests++;
            if (q[i].duty != exp_d[i] || q[i].period != 1200 || q[i].locked != (i == 3)) begin
                n_fail++;
                $display("FAIL short[%0d]: got duty=%0d period=%0d locked=%0d expected %0d 1200 %0d",
                         i, q[i].duty, q[i].period, q[i].locked, exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_static_high();
        int exp_c[3] = '{2401, 4801, 7201};
        apply_reset(1'b1, 1'b1);
        repeat (7300) @(negedge clk);
        n_tests++;
        if (q.size() != 3) begin
            n_fail++; $display("FAIL static_high_count: got %0d expected 3", q.size());
        end
        for (int i = 0; i < q.size() && i < 3; i++) begin
            n_tests++;
            if (q[i].duty != 1200 || q[i].period != 0 || q[i].stat != 1'b1 || q[i].locked != 1'b0 || q[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL static_high[%0d]: got duty=%0d period=%0d static=%0d locked=%0d cyc=%0d expected 1200 0 1 0 %0d",
                         i, q[i].duty, q[i].period, q[i].stat, q[i].locked, q[i].cyc, exp_c[i]);
            end
        end
    endtask

    task automatic test_static_low_then_wave();
        int  exp_d[4] = '{0, 0, 600, 600};
        int  exp_p[4] = '{0, 0, 1200, 1200};
        bit  exp_s[4] = '{1, 1, 0, 0};
        apply_reset(1'b0, 1'b1);
        repeat (5000) @(negedge clk);
        repeat (3) wave(600, 600);
        n_tests++;
        if (q.size() != 4) begin
            n_fail++; $display("FAIL static_low_count: got %0d expected 4", q.size());
        end
        for (int i = 0; i < q.size() && i < 4; i++) begin
            n_tests++;
            if (q[i].duty != exp_d[i] || q[i].period != exp_p[i] || q[i].stat != exp_s[i] || q[i].locked != 1'b0) begin
                n_fail++;
                $display("FAIL static_low[%0d]: got duty=%0d period=%0d static=%0d locked=%0d expected %0d %0d %0d 0",
                         i, q[i].duty, q[i].period, q[i].stat, q[i].locked, exp_d[i], exp_p[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (3) wave(300, 900);
        n_tests++;
        if (q.size() != 2) begin
            n_fail++; $display("FAIL midrst_pre_count: got %0d expected 2", q.size());
        end
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (duty !== '0 || period !== '0 || valid !== 1'b0 || stat !== 1'b0) begin
            n_fail++; $display("FAIL midrst_immediate: got duty=%0d period=%0d valid=%0d expected 0 0 0", duty, period, valid);
        end
        repeat (2) @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        pwm_in = 1'b0;
        repeat (900) @(negedge clk);
        repeat (2) wave(300, 900);
        repeat (10) @(negedge clk);
        n_tests++;
        if (q.size() != 1) begin
            n_fail++; $display("FAIL midrst_post_count: got %0d expected 1", q.size());
        end else begin
            n_tests++;
            if (q[0].duty != 300 || q[0].period != 1200 || q[0].stat != 1'b0) begin
                n_fail++; $display("FAIL midrst_first: got duty=%0d period=%0d static=%0d expected 300 1200 0",
                                   q[0].duty, q[0].period, q[0].stat);
            end
        end
    endtask

    task automatic test_invert();
        int exp_d[4] = '{900, 900, 1200, 1200};
        int exp_p[4] = '{1200, 1200, 1300, 1300};
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        repeat (2) wave_inv(900, 300);
        repeat (2) wave_inv(1201, 99);
        wave_inv(10, 10);
        n_tests++;
        if (qi.size() != 4) begin
            n_fail++; $display("FAIL invert_count: got %0d expected 4", qi.size());
        end
        for (int i = 0; i < qi.size() && i < 4; i++) begin
            n_tests++;
            if (qi[i].duty != exp_d[i] || qi[i].period != exp_p[i] || qi[i].stat != 1'b0 || qi[i].locked != 1'b0) begin
                n_fail++;
                $display("FAIL invert[%0d]: got duty=%0d period=%0d static=%0d locked=%0d expected %0d %0d 0 0",
                         i, qi[i].duty, qi[i].period, qi[i].stat, qi[i].locked, exp_d[i], exp_p[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty25();
        test_relock();
        test_tol_boundary();
        test_short_pulse();
        test_static_high();
        test_static_low_then_wave();
        test_reset_mid_high();
        test_invert();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
